// File: rtl/interleave_pkg.sv
// ============================================================================
// interleave_pkg : shared types and constants for the interleaver frame scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package interleave_pkg;

    localparam int N_DEF          = 7;
    localparam int SYMBOL_NUM_DEF = 5;
    localparam int FRAME_W        = N_DEF * SYMBOL_NUM_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Counter width able to index 0..depth-1, never narrower than one bit.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/symbol_packer.sv
// ============================================================================
// symbol_packer : accepts codewords over a valid/ready handshake and packs
//                 symbol_num of them into one frame buffer.
// Rev 1.0
// ============================================================================
`default_nettype none

module symbol_packer
    import interleave_pkg::*;
#(
    parameter int n          = N_DEF,
    parameter int symbol_num = SYMBOL_NUM_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      sym_valid,
    output logic                      sym_ready,
    input  logic [n-1:0]              sym_data,
    input  logic                      take,
    output logic [n*symbol_num-1:0]   asm_buf,
    output logic                      asm_full
);

    localparam int                   SYM_CNT_W = cnt_width(symbol_num);
    localparam logic [SYM_CNT_W-1:0] LAST_SYM  = SYM_CNT_W'(symbol_num - 1);

    logic [SYM_CNT_W-1:0] sym_cnt;
    logic                 hs;

    assign sym_ready = !asm_full;
    assign hs        = sym_valid && sym_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_cnt  <= '0;
            asm_full <= 1'b0;
            asm_buf  <= '0;
        end else begin
            if (take) begin
                asm_full <= 1'b0;
            end
            // Flush wins over a simultaneous handshake; a full buffer ignores it.
            if (flush && !asm_full) begin
                sym_cnt <= '0;
            end else if (hs) begin
                asm_buf[int'(sym_cnt)*n +: n] <= sym_data;
                if (sym_cnt == LAST_SYM) begin
                    sym_cnt  <= '0;
                    asm_full <= 1'b1;
                end else begin
                    sym_cnt <= sym_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/interleave_sched.sv
// ============================================================================
// interleave_sched : double-buffered frame scheduler around the block
//                    interleaver; fires it once per frame and serialises result.
// Rev 1.0
// ============================================================================
`default_nettype none

module interleave_sched
    import interleave_pkg::*;
#(
    parameter int n          = N_DEF,
    parameter int symbol_num = SYMBOL_NUM_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      sym_valid,
    output logic                      sym_ready,
    input  logic [n-1:0]              sym_data,
    output logic                      il_en,
    output logic [n*symbol_num-1:0]   il_data_o,
    input  logic                      il_eno,
    input  logic [n*symbol_num-1:0]   il_data_i,
    output logic                      bit_valid,
    input  logic                      bit_ready,
    output logic                      bit_data,
    output logic                      frame_start,
    output logic                      frame_done,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic                      err
);

    localparam int                   FW        = n * symbol_num;
    localparam int                   BIT_CNT_W = cnt_width(FW);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FW - 1);

    state_t               state;
    state_t               state_nxt;
    logic [FW-1:0]        asm_buf;
    logic                 asm_full;
    logic                 take;
    logic [FW-1:0]        out_buf;
    logic [BIT_CNT_W-1:0] bit_cnt;

    symbol_packer #(
        .n          (n),
        .symbol_num (symbol_num)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_data  (sym_data),
        .take      (take),
        .asm_buf   (asm_buf),
        .asm_full  (asm_full)
    );

    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        il_en       = 1'b0;
        bit_valid   = 1'b0;
        bit_data    = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (asm_full) begin
                    take      = 1'b1;
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                il_en     = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                bit_valid   = 1'b1;
                bit_data    = out_buf[0];
                frame_start = (bit_cnt == '0);
                if (bit_ready && (bit_cnt == LAST_BIT)) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            il_data_o <= '0;
            out_buf   <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (take) begin
                il_data_o <= asm_buf;
            end
            // The interleaver registered our frame at the end of FIRE.
            if (state == CAPTURE) begin
                out_buf <= il_data_i;
                bit_cnt <= '0;
                if (!il_eno) begin
                    err <= 1'b1;
                end
            end else if ((state == DRAIN) && bit_ready) begin
                out_buf <= out_buf >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_interleave_sched.sv
// ============================================================================
// tb_interleave_sched : directed bench for interleave_sched with a transposing
//                       block-interleaver stand-in.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_interleave_sched;

    localparam int NB = 7;
    localparam int SN = 5;
    localparam int FW = NB * SN;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          sym_valid = 1'b0;
    logic          sym_ready;
    logic [NB-1:0] sym_data = '0;
    logic          il_en;
    logic [FW-1:0] il_data_o;
    logic          il_eno;
    logic [FW-1:0] il_data_i;
    logic          bit_valid;
    logic          bit_ready = 1'b0;
    logic          bit_data;
    logic          frame_start;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;
    logic          err;

    logic          eno_kill = 1'b0;
    logic [FW-1:0] il_q;
    logic          il_v;

    int            n_pass = 0;
    int            n_total = 0;
    int            stall_bad = 0;
    logic [NB-1:0] sym_q[$];

    typedef struct packed {
        logic [FW-1:0] frame;
        logic [FW-1:0] serial;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    interleave_sched dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_data    (sym_data),
        .il_en       (il_en),
        .il_data_o   (il_data_o),
        .il_eno      (il_eno),
        .il_data_i   (il_data_i),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .bit_data    (bit_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .err         (err)
    );

    // Interleaver stand-in: symbol s bit b moves to serial position b*SN+s.
    function automatic logic [FW-1:0] perm(input logic [FW-1:0] x);
        logic [FW-1:0] y = '0;
        for (int s = 0; s < SN; s++)
            for (int b = 0; b < NB; b++)
                y[b*SN+s] = x[s*NB+b];
        return y;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            il_q <= '0;
            il_v <= 1'b0;
        end else if (il_en) begin
            il_q <= perm(il_data_o);
            il_v <= 1'b1;
        end
    end
    assign il_data_i = il_q;
    assign il_eno    = il_v & ~eno_kill;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load_frame(input logic [FW-1:0] f);
        sym_q.delete();
        for (int k = 0; k < SN; k++) sym_q.push_back(f[k*NB +: NB]);
    endtask

    task automatic send_syms();
        int idx = 0;
        int guard = 0;
        while (idx < sym_q.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
            sym_valid = 1'b1;
            sym_data  = sym_q[idx];
            if (sym_ready) idx++;
        end
        @(negedge clk);
        sym_valid = 1'b0;
        sym_data  = '0;
        chk("sym_timeout", idx, sym_q.size());
    endtask

    task automatic collect_frame(input bit rnd, output logic [FW-1:0] bits,
                                 output bit fs_ok, output bit fd_ok, output int gap);
        int   b = 0;
        int   guard = 0;
        logic held_v = 1'b0;
        logic held_d = 1'b0;
        bits = '0; fs_ok = 1'b1; fd_ok = 1'b1; gap = 0;
        while (b < FW && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (held_v && (!bit_valid || bit_data !== held_d)) stall_bad++;
            bit_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            held_v = 1'b0;
            if (!bit_valid) begin
                if (b == 0) gap++;
            end else if (bit_ready) begin
                bits[b] = bit_data;
                if (frame_start !== (b == 0)) fs_ok = 1'b0;
                if (frame_done !== (b == FW - 1)) fd_ok = 1'b0;
                b++;
            end else begin
                held_v = 1'b1;
                held_d = bit_data;
            end
        end
        chk("drain_timeout", b, FW);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] got;
        logic [FW-1:0] bb[3];
        int            gg[3];
        bit            fs_ok, fd_ok;
        int            gap, cnt;

        vecs[0] = {35'h1,          35'h1};
        vecs[1] = {35'h80,         35'h2};
        vecs[2] = {35'h2,          35'h20};
        vecs[3] = {35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF};
        vecs[4] = {35'h7F,         35'h4210_8421};
        vecs[5] = {35'h4_0000_0000, 35'h4_0000_0000};
        vecs[6] = {35'h100_0000,   35'h4_0000};

        repeat (3) @(negedge clk);
        chk("rst_sym_ready",   sym_ready, 1);
        chk("rst_il_en",       il_en, 0);
        chk("rst_il_data_o",   il_data_o, 0);
        chk("rst_bit_valid",   bit_valid, 0);
        chk("rst_bit_data",    bit_data, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_done",  frame_done, 0);
        chk("rst_frame_cnt",   frame_cnt, 0);
        chk("rst_err",         err, 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            load_frame(vecs[i].frame);
            fork
                send_syms();
                collect_frame(1'b0, got, fs_ok, fd_ok, gap);
            join
            chk($sformatf("vec%0d_serial", i), got, vecs[i].serial);
            chk($sformatf("vec%0d_frame_start", i), fs_ok, 1);
            chk($sformatf("vec%0d_frame_done", i), fd_ok, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_frame_cnt", i), frame_cnt, i + 1);
            chk($sformatf("vec%0d_il_data_o", i), il_data_o, vecs[i].frame);
        end
        chk("err_clean", err, 0);

        // Random backpressure on the serial side.
        stall_bad = 0;
        load_frame(35'h7F);
        fork
            send_syms();
            collect_frame(1'b1, got, fs_ok, fd_ok, gap);
        join
        chk("bp_serial", got, 35'h4210_8421);
        chk("bp_stall_stable", stall_bad, 0);
        chk("bp_frame_done", fd_ok, 1);
        @(negedge clk);
        chk("bp_frame_cnt", frame_cnt, 8);

        // Back-to-back: three frames with sym_valid held high.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sym_q.delete();
        sym_q = '{7'h01, 7'h00, 7'h00, 7'h00, 7'h00,
                  7'h02, 7'h00, 7'h00, 7'h00, 7'h00,
                  7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        fork
            send_syms();
            for (int f = 0; f < 3; f++) collect_frame(1'b0, bb[f], fs_ok, fd_ok, gg[f]);
        join
        chk("b2b_serial0", bb[0], 35'h1);
        chk("b2b_serial1", bb[1], 35'h20);
        chk("b2b_serial2", bb[2], 35'h7_FFFF_FFFF);
        chk("b2b_gap1", gg[1], 3);
        chk("b2b_gap2", gg[2], 3);
        @(negedge clk);
        chk("b2b_frame_cnt", frame_cnt, 3);

        // Flush a partial frame; the flush-cycle symbol must be dropped.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sym_q.delete();
        sym_q = '{7'h7F, 7'h7F, 7'h7F};
        send_syms();
        flush = 1'b1; sym_valid = 1'b1; sym_data = 7'h7F;
        @(negedge clk);
        flush = 1'b0; sym_valid = 1'b0; sym_data = '0;
        repeat (5) @(negedge clk);
        chk("flush_no_launch", bit_valid, 0);
        load_frame(35'h1);
        fork
            send_syms();
            collect_frame(1'b0, got, fs_ok, fd_ok, gap);
        join
        chk("flush_serial", got, 35'h1);
        @(negedge clk);
        chk("flush_frame_cnt", frame_cnt, 1);

        // Reset in the middle of DRAIN.
        load_frame(35'h7_FFFF_FFFF);
        send_syms();
        bit_ready = 1'b1;
        cnt = 0;
        while (!bit_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid_reset_reached_drain", bit_valid, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_reset_bit_valid", bit_valid, 0);
        chk("mid_reset_sym_ready", sym_ready, 1);
        chk("mid_reset_frame_cnt", frame_cnt, 0);
        chk("mid_reset_il_data_o", il_data_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bit_valid) cnt++;
        end
        chk("mid_reset_no_output", cnt, 0);

        // il_eno low at capture sets the sticky error; the frame still drains.
        eno_kill = 1'b1;
        load_frame(35'h80);
        fork
            send_syms();
            collect_frame(1'b0, got, fs_ok, fd_ok, gap);
        join
        eno_kill = 1'b0;
        chk("err_serial", got, 35'h2);
        chk("err_set", err, 1);
        load_frame(35'h2);
        fork
            send_syms();
            collect_frame(1'b0, got, fs_ok, fd_ok, gap);
        join
        chk("err_serial2", got, 35'h20);
        @(negedge clk);
        chk("err_sticky", err, 1);
        chk("err_frame_cnt", frame_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
